// File: rtl/pool_window_fetch_pkg.sv
//==============================================================================
// pool_pkg : shared state encoding and helpers for pool_window_fetch
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package pool_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_ADDR0   = 4'd1,
      S_ADDR1   = 4'd2,
      S_ADDR2   = 4'd3,
      S_ADDR3   = 4'd4,
      S_CAP     = 4'd5,
      S_PRESENT = 4'd6,
      S_WAIT    = 4'd7,
      S_WRITE   = 4'd8,
      S_DONE    = 4'd9
   } state_t;

   function automatic int out_w(input int img_w);
      return img_w / 2;
   endfunction

   function automatic int out_h(input int img_h);
      return img_h / 2;
   endfunction

   // Strictly-greater test keeps the first operand on ties.
   function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
      return (b > a) ? b : a;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pool_window_fetch_if.sv
//==============================================================================
// pool_window_fetch_if : control, conv RAM, pooler and pooled RAM signals
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pool_window_fetch_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] conv_raddr;
   logic [DATA_W-1:0] conv_rdata;
   logic [DATA_W-1:0] win0;
   logic [DATA_W-1:0] win1;
   logic [DATA_W-1:0] win2;
   logic [DATA_W-1:0] win3;
   logic              win_valid;
   logic              pool_save;
   logic [DATA_W-1:0] pool_max;
   logic              out_we;
   logic [ADDR_W-1:0] out_waddr;
   logic [DATA_W-1:0] out_wdata;

   modport master (
      input  start, conv_rdata, pool_save, pool_max,
      output busy, done, conv_raddr, win0, win1, win2, win3, win_valid,
             out_we, out_waddr, out_wdata
   );

   modport slave (
      output start, conv_rdata, pool_save, pool_max,
      input  busy, done, conv_raddr, win0, win1, win2, win3, win_valid,
             out_we, out_waddr, out_wdata
   );
endinterface

`default_nettype wire

// File: rtl/pool_window_fetch_addr_gen.sv
//==============================================================================
// pool_addr_gen : window row/column counters, incremental base address and
//                 linear pooled-map output address
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pool_addr_gen #(
   parameter int ADDR_W = 10,
   parameter int IMG_W  = 26,
   parameter int OUT_W  = 13,
   parameter int OUT_H  = 13
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              advance,
   output logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] oaddr,
   output logic              last_window
);
   localparam logic [ADDR_W-1:0] C_COL_STEP = ADDR_W'(2);
   // From the last window of a row to the first of the next: skip the odd
   // column (if any) and the bottom row of the current window pair.
   localparam logic [ADDR_W-1:0] C_ROW_STEP = ADDR_W'(2 * IMG_W - 2 * (OUT_W - 1));
   localparam logic [ADDR_W-1:0] C_LAST_COL = ADDR_W'(OUT_W - 1);
   localparam logic [ADDR_W-1:0] C_LAST_ROW = ADDR_W'(OUT_H - 1);

   logic [ADDR_W-1:0] orow;
   logic [ADDR_W-1:0] ocol;

   always_ff @(posedge clk) begin
      if (clear) begin
         orow  <= '0;
         ocol  <= '0;
         base  <= '0;
         oaddr <= '0;
      end else if (advance) begin
         oaddr <= oaddr + ADDR_W'(1);
         if (ocol == C_LAST_COL) begin
            ocol <= '0;
            orow <= orow + ADDR_W'(1);
            base <= base + C_ROW_STEP;
         end else begin
            ocol <= ocol + ADDR_W'(1);
            base <= base + C_COL_STEP;
         end
      end
   end

   assign last_window = (orow == C_LAST_ROW) && (ocol == C_LAST_COL);

endmodule

`default_nettype wire

// File: rtl/pool_window_fetch.sv
//==============================================================================
// pool_window_fetch : walks a feature map in 2x2 stride-2 windows, feeds the
//                     pooler and writes pooled results to the output RAM.
//                     Option POOL_FETCH_INTERNAL_MAX_EN: compute max internally.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pool_window_fetch
   import pool_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8,
   parameter int IMG_W  = 26,
   parameter int IMG_H  = 26
) (
   input  logic                clk,
   input  logic                rst,
   pool_window_fetch_if.master bus
);
   localparam int OUT_W = out_w(IMG_W);
   localparam int OUT_H = out_h(IMG_H);

   state_t            state;
   state_t            state_nx;
   logic              start_acc;
   logic              clear;
   logic              last_window;
   logic              load_out;
   logic              busy;
   logic              done;
   logic              win_valid;
   logic              out_we;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] oaddr;
   logic [ADDR_W-1:0] raddr;
   logic [ADDR_W-1:0] raddr_hold;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] next_wdata;
   logic [DATA_W-1:0] win0, win1, win2, win3;

   assign start_acc = (state == S_IDLE) && bus.start;
   assign clear     = rst || start_acc;

   pool_addr_gen #(
      .ADDR_W (ADDR_W),
      .IMG_W  (IMG_W),
      .OUT_W  (OUT_W),
      .OUT_H  (OUT_H)
   ) u_addr_gen (
      .clk         (clk),
      .clear       (clear),
      .advance     (out_we),
      .base        (base),
      .oaddr       (oaddr),
      .last_window (last_window)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      busy      = 1'b1;
      done      = 1'b0;
      win_valid = 1'b0;
      out_we    = 1'b0;
      raddr     = raddr_hold;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (bus.start) state_nx = S_ADDR0;
         end
         S_ADDR0: begin
            raddr    = base;
            state_nx = S_ADDR1;
         end
         S_ADDR1: begin
            raddr    = base + ADDR_W'(1);
            state_nx = S_ADDR2;
         end
         S_ADDR2: begin
            raddr    = base + ADDR_W'(IMG_W);
            state_nx = S_ADDR3;
         end
         S_ADDR3: begin
            raddr    = base + ADDR_W'(IMG_W + 1);
            state_nx = S_CAP;
         end
         S_CAP:     state_nx = S_PRESENT;
         S_PRESENT: begin
            win_valid = 1'b1;
`ifdef POOL_FETCH_INTERNAL_MAX_EN
            state_nx  = S_WRITE;
`else
            state_nx  = S_WAIT;
`endif
         end
         S_WAIT: begin
            if (bus.pool_save) state_nx = S_WRITE;
         end
         S_WRITE: begin
            out_we   = 1'b1;
            state_nx = last_window ? S_DONE : S_ADDR0;
         end
         S_DONE: begin
            busy     = 1'b0;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = S_IDLE;
         end
      endcase
   end

`ifdef POOL_FETCH_INTERNAL_MAX_EN
   logic signed [31:0] sx0, sx1, sx2, sx3;
   assign sx0        = 32'(signed'(win0));
   assign sx1        = 32'(signed'(win1));
   assign sx2        = 32'(signed'(win2));
   assign sx3        = 32'(signed'(win3));
   assign next_wdata = DATA_W'(smax(smax(smax(sx0, sx1), sx2), sx3));
`else
   assign next_wdata = bus.pool_max;
`endif

   // Output address/data only move on entry to S_WRITE, so they hold otherwise.
   assign load_out = (state_nx == S_WRITE);

   always_ff @(posedge clk) begin
      if (rst) begin
         raddr_hold <= '0;
         win0       <= '0;
         win1       <= '0;
         win2       <= '0;
         win3       <= '0;
         waddr      <= '0;
         wdata      <= '0;
      end else begin
         raddr_hold <= raddr;
         case (state)
            S_ADDR1: win0 <= bus.conv_rdata;
            S_ADDR2: win1 <= bus.conv_rdata;
            S_ADDR3: win2 <= bus.conv_rdata;
            S_CAP:   win3 <= bus.conv_rdata;
            default: ;
         endcase
         if (load_out) begin
            waddr <= oaddr;
            wdata <= next_wdata;
         end
      end
   end

   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.conv_raddr = raddr;
   assign bus.win0       = win0;
   assign bus.win1       = win1;
   assign bus.win2       = win2;
   assign bus.win3       = win3;
   assign bus.win_valid  = win_valid;
   assign bus.out_we     = out_we;
   assign bus.out_waddr  = waddr;
   assign bus.out_wdata  = wdata;

endmodule

`default_nettype wire

// File: tb/tb_pool_window_fetch.sv
//==============================================================================
// tb_pool_window_fetch : self-checking bench, 4x4 and 5x5 instances with RAM
//                        and pooler models. Honours POOL_FETCH_INTERNAL_MAX_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pool_window_fetch;

   logic clk;
   logic rst;
   logic start4, start5;
   logic ps_inj;
   int   total, bad;
   int   cyc;

   pool_window_fetch_if #(.ADDR_W(10), .DATA_W(8)) if4 ();
   pool_window_fetch_if #(.ADDR_W(10), .DATA_W(8)) if5 ();

   pool_window_fetch #(.ADDR_W(10), .DATA_W(8), .IMG_W(4), .IMG_H(4)) u_dut4 (
      .clk (clk), .rst (rst), .bus (if4.master));
   pool_window_fetch #(.ADDR_W(10), .DATA_W(8), .IMG_W(5), .IMG_H(5)) u_dut5 (
      .clk (clk), .rst (rst), .bus (if5.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] max4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
      logic signed [7:0] m;
      m = a;
      if ($signed(b) > m) m = b;
      if ($signed(c) > m) m = c;
      if ($signed(d) > m) m = d;
      return m;
   endfunction

   // RAMs and pooler models
   logic [7:0] mem4 [0:1023];
   logic [7:0] mem5 [0:1023];
   int         pdelay4 = 3;
   int         pcnt4 = 0, pcnt5 = 0;
   logic       psm4 = 1'b0, psm5 = 1'b0;
   logic [7:0] pmax4 = 8'h00, pmax5 = 8'h00;

   always @(posedge clk) if4.conv_rdata <= mem4[if4.conv_raddr];
   always @(posedge clk) if5.conv_rdata <= mem5[if5.conv_raddr];

   always @(posedge clk) begin
      if (rst) begin
         pcnt4 <= 0;
         psm4  <= 1'b0;
      end else begin
         psm4 <= 1'b0;
         if (if4.win_valid) begin
            pcnt4 <= pdelay4;
            pmax4 <= max4(if4.win0, if4.win1, if4.win2, if4.win3);
         end else if (pcnt4 > 0) begin
            pcnt4 <= pcnt4 - 1;
            if (pcnt4 == 1) psm4 <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         pcnt5 <= 0;
         psm5  <= 1'b0;
      end else begin
         psm5 <= 1'b0;
         if (if5.win_valid) begin
            pcnt5 <= 2;
            pmax5 <= max4(if5.win0, if5.win1, if5.win2, if5.win3);
         end else if (pcnt5 > 0) begin
            pcnt5 <= pcnt5 - 1;
            if (pcnt5 == 1) psm5 <= 1'b1;
         end
      end
   end

   assign if4.start     = start4;
   assign if5.start     = start5;
   assign if4.pool_save = psm4 | ps_inj;
   assign if4.pool_max  = ps_inj ? 8'h7F : pmax4;
   assign if5.pool_save = psm5;
   assign if5.pool_max  = pmax5;

   // Monitors (only writers of the logs)
   int          wa4[$], wc4[$], wa5[$];
   logic [7:0]  wd4[$], wd5[$];
   logic [31:0] wv4[$];
   int          done4 = 0, done5 = 0;
   bit          seen5 [0:1023];

   always @(negedge clk) begin
      if (!rst) begin
         if (if4.out_we) begin
            wa4.push_back(int'(if4.out_waddr));
            wd4.push_back(if4.out_wdata);
            wc4.push_back(cyc);
         end
         if (if4.done) done4 = done4 + 1;
         if (if4.win_valid) wv4.push_back({if4.win0, if4.win1, if4.win2, if4.win3});
         if (if5.out_we) begin
            wa5.push_back(int'(if5.out_waddr));
            wd5.push_back(if5.out_wdata);
         end
         if (if5.done) done5 = done5 + 1;
         if (if5.busy) seen5[if5.conv_raddr] = 1'b1;
      end
   end

`ifdef POOL_FETCH_INTERNAL_MAX_EN
   function automatic int gap_for(input int d); return 7 + 0 * d; endfunction
`else
   // S_WAIT lasts d+1 cycles with this pooler model.
   function automatic int gap_for(input int d); return 8 + d; endfunction
`endif

   task automatic do_pass4(input int delay, input bit inj);
      int n;
      bit seen_done;
      pdelay4 = delay;
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      n = 1;
      seen_done = 1'b0;
      while (!seen_done && n < 3000) begin
         if (inj && n == 3)  ps_inj = 1'b1;
         if (inj && n == 4)  ps_inj = 1'b0;
         if (inj && n == 10) start4 = 1'b1;
         if (inj && n == 11) start4 = 1'b0;
         if (if4.done) seen_done = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      total++;
      if (!seen_done) begin
         bad++;
         $display("FAIL pass_timeout: no done after %0d cycles, required done", n);
      end
      if (inj && seen_done) begin
         start4 = 1'b1;
         @(negedge clk) start4 = 1'b0;
      end
   endtask

   task automatic test_full_pass4(input string tag, input int delay, input bit inj);
      int st, db;
      int ea[$];
      logic [7:0] ed[$];
      st = wa4.size();
      db = done4;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            int b;
            b = 2 * r * 4 + 2 * c;
            ea.push_back(r * 2 + c);
            ed.push_back(max4(mem4[b], mem4[b+1], mem4[b+4], mem4[b+5]));
         end
      do_pass4(delay, inj);
      repeat (5) @(negedge clk);
      total++;
      if (if4.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy_after: got %b want 0", tag, if4.busy);
      end
      total++;
      if (done4 - db !== 1) begin
         bad++;
         $display("FAIL %s done_count: got %0d want 1", tag, done4 - db);
      end
      total++;
      if (wa4.size() - st !== 4) begin
         bad++;
         $display("FAIL %s write_count: got %0d want 4", tag, wa4.size() - st);
      end
      for (int i = 0; i < 4; i++) begin
         if (st + i < wa4.size()) begin
            total++;
            if (wa4[st+i] !== ea[i] || wd4[st+i] !== ed[i]) begin
               bad++;
               $display("FAIL %s write%0d: got (%0d,%h) want (%0d,%h)", tag, i,
                        wa4[st+i], wd4[st+i], ea[i], ed[i]);
            end
            if (i > 0) begin
               total++;
               if (wc4[st+i] - wc4[st+i-1] !== gap_for(delay)) begin
                  bad++;
                  $display("FAIL %s gap%0d: got %0d want %0d", tag, i,
                           wc4[st+i] - wc4[st+i-1], gap_for(delay));
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({if4.busy, if4.done, if4.win_valid, if4.out_we} !== 4'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 0000",
                  {if4.busy, if4.done, if4.win_valid, if4.out_we});
      end
      total++;
      if ({if4.conv_raddr, if4.out_waddr, if4.out_wdata} !== 28'h0) begin
         bad++;
         $display("FAIL reset_addr: got %h/%h/%h want 0", if4.conv_raddr,
                  if4.out_waddr, if4.out_wdata);
      end
      total++;
      if ({if4.win0, if4.win1, if4.win2, if4.win3} !== 32'h0) begin
         bad++;
         $display("FAIL reset_win: got %h want 0", {if4.win0, if4.win1, if4.win2, if4.win3});
      end
      total++;
      if ({if5.busy, if5.out_we, if5.conv_raddr} !== 12'h0) begin
         bad++;
         $display("FAIL reset_dut5: got %h want 0", {if5.busy, if5.out_we, if5.conv_raddr});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ramp();
      for (int i = 0; i < 16; i++) mem4[i] = 8'(i);
      test_full_pass4("ramp", 3, 1'b0);
   endtask

   task automatic test_negative_window();
      int vst, st;
      for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom_range(0, 255));
      mem4[0] = 8'h80; mem4[1] = 8'hFF; mem4[4] = 8'hFB; mem4[5] = 8'hFD;
      vst = wv4.size();
      st  = wd4.size();
      test_full_pass4("neg", 2, 1'b0);
      total++;
      if (vst >= wv4.size() || wv4[vst] !== 32'h80FFFBFD) begin
         bad++;
         $display("FAIL neg_window: got %h want 80fffbfd",
                  (vst < wv4.size()) ? wv4[vst] : 32'hx);
      end
      total++;
      if (st >= wd4.size() || wd4[st] !== 8'hFF) begin
         bad++;
         $display("FAIL neg_wdata: got %h want ff", (st < wd4.size()) ? wd4[st] : 8'hx);
      end
   endtask

   task automatic test_odd_geometry();
      int n;
      int unread[7];
      int want[4];
      unread = '{4, 9, 14, 19, 20, 22, 24};
      want   = '{6, 8, 16, 18};
      for (int i = 0; i < 1024; i++) mem5[i] = 8'(i);
      @(negedge clk) start5 = 1'b1;
      @(negedge clk) start5 = 1'b0;
      n = 0;
      while (!if5.done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!if5.done) begin
         bad++;
         $display("FAIL odd_timeout: no done after %0d cycles", n);
      end
      repeat (3) @(negedge clk);
      total++;
      if (wa5.size() !== 4 || done5 !== 1) begin
         bad++;
         $display("FAIL odd_counts: got writes=%0d dones=%0d want 4/1", wa5.size(), done5);
      end
      for (int i = 0; i < 4 && i < wa5.size(); i++) begin
         total++;
         if (wa5[i] !== i || wd5[i] !== 8'(want[i])) begin
            bad++;
            $display("FAIL odd_write%0d: got (%0d,%0d) want (%0d,%0d)", i, wa5[i], wd5[i],
                     i, want[i]);
         end
      end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (seen5[unread[i]] !== 1'b0) begin
            bad++;
            $display("FAIL odd_unread: address %0d got read, want never read", unread[i]);
         end
      end
      total++;
      if ({seen5[0], seen5[2], seen5[10], seen5[12], seen5[18]} !== 5'b11111) begin
         bad++;
         $display("FAIL odd_bases: got %b want 11111",
                  {seen5[0], seen5[2], seen5[10], seen5[12], seen5[18]});
      end
   endtask

   task automatic test_busy_ignore();
      for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom_range(0, 255));
      test_full_pass4("busy_ignore", 3, 1'b1);
   endtask

   task automatic test_reset_mid();
      int vst, wst, db, n, rvst;
      for (int i = 0; i < 16; i++) mem4[i] = 8'(i);
      pdelay4 = 4;
      vst = wv4.size();
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      n = 0;
      while (wv4.size() - vst < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (wv4.size() - vst < 3) begin
         bad++;
         $display("FAIL mid_timeout: windows got %0d want 3", wv4.size() - vst);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({if4.busy, if4.done, if4.win_valid, if4.out_we, if4.conv_raddr,
           if4.out_waddr, if4.out_wdata, if4.win0} !== 40'h0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got busy=%b raddr=%h waddr=%h wdata=%h want 0",
                  if4.busy, if4.conv_raddr, if4.out_waddr, if4.out_wdata);
      end
      rst = 1'b0;
      wst = wa4.size();
      db  = done4;
      repeat (30) @(negedge clk);
      total++;
      if (wa4.size() !== wst || done4 !== db) begin
         bad++;
         $display("FAIL mid_quiet: got writes=%0d dones=%0d want 0/0", wa4.size() - wst,
                  done4 - db);
      end
      rvst = wv4.size();
      test_full_pass4("restart", 4, 1'b0);
      total++;
      if (rvst >= wv4.size() || wv4[rvst] !== 32'h00010405) begin
         bad++;
         $display("FAIL restart_window: got %h want 00010405",
                  (rvst < wv4.size()) ? wv4[rvst] : 32'hx);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom_range(0, 255));
         test_full_pass4("random", int'($urandom_range(1, 5)), 1'b0);
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b1;
      start4 = 1'b0;
      start5 = 1'b0;
      ps_inj = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         mem4[i]  = 8'h00;
         mem5[i]  = 8'h00;
         seen5[i] = 1'b0;
      end
      test_reset();
      test_ramp();
      test_negative_window();
      test_odd_geometry();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
